// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps at most one I-cache read outstanding and queues returned words for decode.
// Define INST_FETCH_QUEUE_BYPASS_EN to hand a response straight to decode when the queue is empty.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   imem_read,
    output logic [31:0]            imem_address,
    input  logic                   imem_resp,
    input  logic [31:0]            imem_rdata,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [31:0]            deq_instr,
    output logic [31:0]            deq_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state_reg;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     stale_pc_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem [DEPTH];

    logic [31:0]     target_pc;
    logic            fifo_empty;
    logic            resp_ok;
    logic            bypass_hit;
    logic            do_enq;
    logic            do_deq;
    logic [CW-1:0]   count_next;

    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign fifo_empty = (count_reg == '0);
    assign resp_ok    = (state_reg == FETCH) && imem_resp && !redirect;

    assign imem_read    = (state_reg == FETCH) || (state_reg == DISCARD);
    assign imem_address = (state_reg == DISCARD) ? stale_pc_reg : fetch_pc_reg;
    assign count        = count_reg;

    always_comb begin
        bypass_hit = 1'b0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        bypass_hit = fifo_empty && resp_ok;
`else
        bypass_hit = 1'b0;
`endif
        deq_valid = (!fifo_empty && !redirect) || bypass_hit;
        deq_instr = '0;
        deq_pc    = '0;
        if (bypass_hit) begin
            deq_instr = imem_rdata;
            deq_pc    = fetch_pc_reg;
        end else if (!fifo_empty) begin
            deq_instr = instr_mem[rd_ptr_reg];
            deq_pc    = pc_mem[rd_ptr_reg];
        end
        do_deq = !fifo_empty && !redirect && deq_ready;
        // A bypassed word that decode takes immediately never occupies a slot
        do_enq = resp_ok && !(bypass_hit && deq_ready);
        count_next = count_reg + CW'(do_enq) - CW'(do_deq);
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (do_enq) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_deq) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            stale_pc_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_reg <= target_pc;
                    end else if (count_reg < CW'(DEPTH)) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        fetch_pc_reg <= target_pc;
                        if (imem_resp) begin
                            state_reg <= IDLE;
                        end else begin
                            // Request must stay on the bus until the cache answers it
                            state_reg    <= DISCARD;
                            stale_pc_reg <= fetch_pc_reg;
                        end
                    end else if (imem_resp) begin
                        fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        state_reg    <= (count_next < CW'(DEPTH)) ? FETCH : IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc_reg <= target_pc;
                    end
                    if (imem_resp) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: responder models the I-cache, monitor checks every dequeue
// against an expected in-order PC stream that restarts on reset and redirect.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   imem_read;
    logic [31:0]            imem_address;
    logic                   imem_resp;
    logic [31:0]            imem_rdata;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [31:0]            deq_instr;
    logic [31:0]            deq_pc;
    logic [$clog2(DEPTH):0] count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_deq    = 0;
    int          mem_lat  = 2;
    bit          rand_lat = 1'b0;
    exp_t        exp_q[$];
    exp_t        exp_e;
    logic [31:0] sb_next_pc = '0;

    bit          rsp_pend = 1'b0;
    int          rsp_wait = 0;
    logic [31:0] rsp_addr = '0;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h00000060)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_instr    (deq_instr),
        .deq_pc       (deq_pc),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h60) return 32'h00000013;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic void sb_refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: sb_next_pc, instr: mem_fn(sb_next_pc)});
            sb_next_pc = sb_next_pc + 32'd4;
        end
    endfunction

    // After reset/redirect decode must see target, target+4, ... with nothing older
    function automatic void sb_restart(input logic [31:0] pc);
        exp_q.delete();
        sb_next_pc = pc & 32'hFFFF_FFFC;
        sb_refill();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_addr(input logic [31:0] addr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (imem_read && imem_address == addr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_resp(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (imem_resp) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_deq(input int n, input int budget, output bit ok);
        int target;
        target = n_deq + n;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_deq >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b0;
        sb_restart(32'h60);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // I-cache model: answers each request mem_lat cycles after it first appears
    initial begin
        imem_resp  = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1 || !imem_read) begin
                rsp_pend  = 1'b0;
                imem_resp = 1'b0;
            end else begin
                if (imem_resp) begin
                    rsp_pend  = 1'b0;
                    imem_resp = 1'b0;
                end
                if (!rsp_pend) begin
                    rsp_pend = 1'b1;
                    rsp_addr = imem_address;
                    rsp_wait = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
                    check("addr_aligned", {30'd0, imem_address[1:0]}, 32'd0);
                end else begin
                    check("addr_hold", imem_address, rsp_addr);
                end
                rsp_wait--;
                if (rsp_wait <= 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = mem_fn(rsp_addr);
                end
            end
        end
    end

    // Monitor: every accepted head entry must be the next expected PC/instruction
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                assert (!(imem_resp && imem_read && !redirect && count == ($clog2(DEPTH)+1)'(DEPTH)))
                else begin
                    n_checks++;
                    $display("FAIL write_while_full: response with count=%0d", count);
                end
                if (deq_valid && deq_ready) begin
                    exp_e = exp_q.pop_front();
                    $display("deq #%0d pc=%h instr=%h", n_deq, deq_pc, deq_instr);
                    check("deq_pc", deq_pc, exp_e.pc);
                    check("deq_instr", deq_instr, exp_e.instr);
                    n_deq++;
                    sb_refill();
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int target;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        deq_ready   = 1'b0;
        sb_restart(32'h60);

        // Reset state
        repeat (2) cyc();
        @(negedge clk);
        check("rst_imem_read", {31'd0, imem_read}, 32'd0);
        check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_pc", deq_pc, 32'd0);
        check("rst_deq_instr", deq_instr, 32'd0);

        // First fetch after release
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("read_at_release", {31'd0, imem_read}, 32'd0);
        @(negedge clk);
        check("first_read", {31'd0, imem_read}, 32'd1);
        check("first_addr", imem_address, 32'h60);
        wait_resp(10, ok);
        check("first_resp_seen", {31'd0, ok}, 32'd1);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        check("bypass_valid", {31'd0, deq_valid}, 32'd1);
        check("bypass_pc", deq_pc, 32'h60);
`else
        check("valid_not_same_cycle", {31'd0, deq_valid}, 32'd0);
`endif
        @(negedge clk);
        check("first_valid", {31'd0, deq_valid}, 32'd1);
        check("first_pc", deq_pc, 32'h60);
        check("first_instr", deq_instr, 32'h13);
        check("second_addr", imem_address, 32'h64);

        // Fill with 1-cycle responses and no consumer
        mem_lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (count == 3'd4) begin
                ok = 1'b1;
                break;
            end
        end
        check("fill_reached", {31'd0, ok}, 32'd1);
        check("full_read_off", {31'd0, imem_read}, 32'd0);
        check("full_head_pc", deq_pc, 32'h60);
        cyc();
        deq_ready = 1'b1;
        @(negedge clk);
        cyc();
        deq_ready = 1'b0;
        @(negedge clk);
        check("after_pop_count", 32'(count), 32'd3);
        check("after_pop_read", {31'd0, imem_read}, 32'd0);
        @(negedge clk);
        check("refetch_read", {31'd0, imem_read}, 32'd1);
        check("refetch_addr", imem_address, 32'h70);
        @(negedge clk);
        check("refill_count", 32'(count), 32'd4);
        check("refill_read", {31'd0, imem_read}, 32'd0);
        cyc();
        deq_ready = 1'b1;
        wait_deq(5, 40, ok);
        check("drain_done", {31'd0, ok}, 32'd1);
        deq_ready = 1'b0;

        // Redirect while a request to 0x68 is outstanding
        mem_lat = 4;
        do_reset();
        wait_addr(32'h68, 40, ok);
        check("req68_seen", {31'd0, ok}, 32'd1);
        check("count_before_redirect", 32'(count), 32'd2);
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        sb_restart(32'h200);
        @(negedge clk);
        check("redirect_valid_low", {31'd0, deq_valid}, 32'd0);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        check("redirect_count", 32'(count), 32'd0);
        check("discard_read", {31'd0, imem_read}, 32'd1);
        check("discard_addr", imem_address, 32'h68);
        wait_resp(10, ok);
        check("discard_resp", {31'd0, ok}, 32'd1);
        check("discard_resp_addr", imem_address, 32'h68);
        @(negedge clk);
        check("dropped_count", 32'(count), 32'd0);
        check("idle_after_discard", {31'd0, imem_read}, 32'd0);
        @(negedge clk);
        check("target_read", {31'd0, imem_read}, 32'd1);
        check("target_addr", imem_address, 32'h200);

        // Redirect coinciding with a response and with deq_ready
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (imem_resp && imem_address == 32'h204) begin
                ok = 1'b1;
                break;
            end
        end
        check("resp204_seen", {31'd0, ok}, 32'd1);
        check("count_before_collide", 32'(count), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        deq_ready   = 1'b1;
        sb_restart(32'h300);
        @(negedge clk);
        check("collide_valid_low", {31'd0, deq_valid}, 32'd0);
        cyc();
        redirect  = 1'b0;
        deq_ready = 1'b0;
        @(negedge clk);
        check("collide_count", 32'(count), 32'd0);
        check("collide_idle", {31'd0, imem_read}, 32'd0);
        @(negedge clk);
        check("collide_target_addr", imem_address, 32'h300);

        // Random-latency stream with random consumer after an unaligned redirect
        rand_lat = 1'b1;
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        sb_restart(32'h203);
        cyc();
        redirect = 1'b0;
        wait_addr(32'h200, 20, ok);
        check("unaligned_target", {31'd0, ok}, 32'd1);
        target = n_deq + 10;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            deq_ready = 1'($urandom_range(0, 1));
            if (n_deq >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("stream_done", {31'd0, ok}, 32'd1);
        deq_ready = 1'b0;

        // Asynchronous reset in the middle of a fetch
        rand_lat = 1'b0;
        mem_lat  = 3;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count != '0 && imem_read) begin
                ok = 1'b1;
                break;
            end
        end
        check("midfetch_seen", {31'd0, ok}, 32'd1);
        cyc();
        rst = 1'b0;
        sb_restart(32'h60);
        #1;
        check("async_read", {31'd0, imem_read}, 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_valid", {31'd0, deq_valid}, 32'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("restart_idle", {31'd0, imem_read}, 32'd0);
        @(negedge clk);
        check("restart_read", {31'd0, imem_read}, 32'd1);
        check("restart_addr", imem_address, 32'h60);
        deq_ready = 1'b1;
        wait_deq(4, 60, ok);
        check("restart_stream", {31'd0, ok}, 32'd1);
        deq_ready = 1'b0;

        repeat (2) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
